gate16_checker: RTL and testbench

//   Synthesizable response checker for the 16-bit two-input logic gates
//   (gand16, gor16, gxor16, ...). It receives operand/result triples from a

---
 rtl/gate16_checker_if.sv | 19 +
 rtl/gate16_checker.sv | 153 +++++++++++++++
 tb/tb_gate16_checker.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/gate16_checker_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gate16_checker_if                                                      |
// | Operand/result vector handshake from a stimulus source to the checker. |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
interface gate16_checker_if #(
  parameter int WIDTH = 16
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_in1;
  logic [WIDTH-1:0] s_in2;
  logic [WIDTH-1:0] s_out;

  modport master (output s_valid, s_in1, s_in2, s_out, input s_ready);
  modport slave  (input s_valid, s_in1, s_in2, s_out, output s_ready);
endinterface
`default_nettype wire

// File: rtl/gate16_checker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | gate16_checker                                                         |
// | Checks 16-bit two-input gate responses; counts vectors and mismatches. |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module gate16_checker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op_sel,
  input  logic [CNT_W-1:0]  num_vec,
  gate16_checker_if.slave   s_if,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              op_err,
  output logic [CNT_W-1:0]  vec_cnt,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  first_fail_idx,
  output logic [WIDTH-1:0]  first_fail_got,
  output logic [WIDTH-1:0]  first_fail_exp
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [2:0]       c_OP_RSVD = 3'd7;
  localparam logic [CNT_W-1:0] c_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state, w_state_nxt;
  logic             w_ready, w_start_ok, w_hs, w_last, w_miss;
  logic [WIDTH-1:0] w_exp;

  logic [2:0]       r_op;
  logic             r_op_err;
  logic [CNT_W-1:0] r_num_vec, r_acc_cnt, r_vec_cnt, r_err_cnt, r_ff_idx;
  logic [WIDTH-1:0] r_ff_got, r_ff_exp;
  logic             r_stg_vld;
  logic [WIDTH-1:0] r_stg_in1, r_stg_in2, r_stg_out;

  assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_hs       = s_if.s_valid && (r_state == S_RUN);
  assign w_last     = w_hs && (r_acc_cnt == (r_num_vec - c_ONE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) w_state_nxt = (num_vec == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        w_ready = 1'b1;
        if (w_last) w_state_nxt = S_FLUSH;
      end
      S_FLUSH: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Expected value is computed from the staged operands, one cycle after capture.
  always_comb begin
    w_exp = '0;
    case (r_op)
      3'd0:    w_exp = r_stg_in1 & r_stg_in2;
      3'd1:    w_exp = r_stg_in1 | r_stg_in2;
      3'd2:    w_exp = r_stg_in1 ^ r_stg_in2;
      3'd3:    w_exp = ~(r_stg_in1 & r_stg_in2);
      3'd4:    w_exp = ~(r_stg_in1 | r_stg_in2);
      3'd5:    w_exp = ~(r_stg_in1 ^ r_stg_in2);
      3'd6:    w_exp = ~r_stg_in1;
      default: w_exp = '0;
    endcase
  end

  assign w_miss = (r_stg_out != w_exp) || r_op_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_op_err  <= 1'b0;
      r_num_vec <= '0;
      r_acc_cnt <= '0;
      r_vec_cnt <= '0;
      r_err_cnt <= '0;
      r_ff_idx  <= '0;
      r_ff_got  <= '0;
      r_ff_exp  <= '0;
      r_stg_vld <= 1'b0;
      r_stg_in1 <= '0;
      r_stg_in2 <= '0;
      r_stg_out <= '0;
    end else begin
      r_stg_vld <= w_hs;
      if (w_hs) begin
        r_stg_in1 <= s_if.s_in1;
        r_stg_in2 <= s_if.s_in2;
        r_stg_out <= s_if.s_out;
        r_acc_cnt <= r_acc_cnt + c_ONE;
      end
      if (r_stg_vld) begin
        r_vec_cnt <= r_vec_cnt + c_ONE;
        if (w_miss) begin
          r_err_cnt <= r_err_cnt + c_ONE;
          // The committed count equals the staged vector's 0-based index.
          if (r_err_cnt == '0) begin
            r_ff_idx <= r_vec_cnt;
            r_ff_got <= r_stg_out;
            r_ff_exp <= w_exp;
          end
        end
      end
      if (w_start_ok) begin
        r_op      <= op_sel;
        r_op_err  <= (op_sel == c_OP_RSVD);
        r_num_vec <= num_vec;
        r_acc_cnt <= '0;
        r_vec_cnt <= '0;
        r_err_cnt <= '0;
        r_ff_idx  <= '0;
        r_ff_got  <= '0;
        r_ff_exp  <= '0;
        r_stg_vld <= 1'b0;
      end
    end
  end

  assign s_if.s_ready   = w_ready;
  assign busy           = (r_state == S_RUN) || (r_state == S_FLUSH);
  assign done           = (r_state == S_DONE);
  assign pass           = done && (r_err_cnt == '0) && !r_op_err;
  assign op_err         = r_op_err;
  assign vec_cnt        = r_vec_cnt;
  assign err_cnt        = r_err_cnt;
  assign first_fail_idx = r_ff_idx;
  assign first_fail_got = r_ff_got;
  assign first_fail_exp = r_ff_exp;

endmodule
`default_nettype wire

// File: tb/tb_gate16_checker.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_gate16_checker                                                      |
// | Randomized self-checking bench for gate16_checker with truth-table ref.|
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_gate16_checker;
  localparam int WIDTH = 16;
  localparam int CNT_W = 16;

  logic             clk     = 1'b0;
  logic             rst_n   = 1'b0;
  logic             start   = 1'b0;
  logic [2:0]       op_sel  = 3'd0;
  logic [CNT_W-1:0] num_vec = '0;
  logic             busy, done, pass, op_err;
  logic [CNT_W-1:0] vec_cnt, err_cnt, first_fail_idx;
  logic [WIDTH-1:0] first_fail_got, first_fail_exp;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] va [16];
  logic [15:0] vb [16];
  logic [15:0] vo [16];

  gate16_checker_if #(.WIDTH(WIDTH)) s_if ();

  gate16_checker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .op_sel         (op_sel),
    .num_vec        (num_vec),
    .s_if           (s_if.slave),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .op_err         (op_err),
    .vec_cnt        (vec_cnt),
    .err_cnt        (err_cnt),
    .first_fail_idx (first_fail_idx),
    .first_fail_got (first_fail_got),
    .first_fail_exp (first_fail_exp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Per-bit truth table lookup, index {a,b}.
  function automatic logic [15:0] ref_gate(input int op, input logic [15:0] a, input logic [15:0] b);
    logic [3:0]  lut;
    logic [15:0] r;
    case (op)
      0:       lut = 4'b1000;
      1:       lut = 4'b1110;
      2:       lut = 4'b0110;
      3:       lut = 4'b0111;
      4:       lut = 4'b0001;
      5:       lut = 4'b1001;
      6:       lut = 4'b0011;
      default: lut = 4'b0000;
    endcase
    for (int k = 0; k < 16; k++) r[k] = lut[{a[k], b[k]}];
    return r;
  endfunction

  task automatic run_vectors(input int op, input int n, input int gap_min, input int gap_max, input int ign_at);
    int          e_err, e_idx, gaps;
    logic [15:0] e_got, e_exp, x;
    bit          e_op_err;
    e_op_err = (op == 7);
    e_err = 0; e_idx = 0; e_got = '0; e_exp = '0;
    for (int i = 0; i < n; i++) begin
      x = ref_gate(op, va[i], vb[i]);
      if (vo[i] !== x || e_op_err) begin
        if (e_err == 0) begin
          e_idx = i; e_got = vo[i]; e_exp = x;
        end
        e_err++;
      end
    end

    op_sel  = 3'(op);
    num_vec = 16'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_vec_cnt", 32'(vec_cnt), 0);
    check("start_err_cnt", 32'(err_cnt), 0);
    check("start_ff_idx",  32'(first_fail_idx), 0);
    check("start_ff_got",  32'(first_fail_got), 0);
    check("start_busy",    32'(busy), 32'(n != 0));
    check("start_done",    32'(done), 32'(n == 0));
    check("start_op_err",  32'(op_err), 32'(e_op_err));

    for (int i = 0; i < n; i++) begin
      gaps = (gap_max > 0) ? int'($urandom_range(gap_max, gap_min)) : 0;
      for (int g = 0; g < gaps; g++) begin
        s_if.s_valid = 1'b0;
        @(posedge clk); #1;
        check("gap_vec_cnt", 32'(vec_cnt), i);
      end
      s_if.s_valid = 1'b1;
      s_if.s_in1   = va[i];
      s_if.s_in2   = vb[i];
      s_if.s_out   = vo[i];
      if (i == ign_at) begin
        start   = 1'b1;
        num_vec = '0;
        op_sel  = 3'(op) ^ 3'd1;
      end
      check("run_ready", 32'(s_if.s_ready), 1);
      @(posedge clk); #1;
      start   = 1'b0;
      op_sel  = 3'(op);
      num_vec = 16'(n);
      check("lat_vec_cnt", 32'(vec_cnt), i);
    end
    s_if.s_valid = 1'b0;
    s_if.s_in1   = 16'($urandom);
    s_if.s_in2   = 16'($urandom);
    s_if.s_out   = 16'($urandom);
    if (n > 0) begin
      check("flush_done",  32'(done), 0);
      check("flush_busy",  32'(busy), 1);
      check("flush_ready", 32'(s_if.s_ready), 0);
    end
    @(posedge clk); #1;
    check("end_done",    32'(done), 1);
    check("end_busy",    32'(busy), 0);
    check("end_ready",   32'(s_if.s_ready), 0);
    check("end_vec_cnt", 32'(vec_cnt), n);
    check("end_err_cnt", 32'(err_cnt), e_err);
    check("end_ff_idx",  32'(first_fail_idx), e_idx);
    check("end_ff_got",  32'(first_fail_got), 32'(e_got));
    check("end_ff_exp",  32'(first_fail_exp), 32'(e_exp));
    check("end_pass",    32'(pass), 32'(e_err == 0 && !e_op_err));
  endtask

  task automatic fill_random(input int op, input int n, input int bad_pct);
    for (int i = 0; i < n; i++) begin
      va[i] = 16'($urandom);
      vb[i] = 16'($urandom);
      vo[i] = ref_gate(op, va[i], vb[i]);
      if (int'($urandom_range(99, 0)) < bad_pct) vo[i] = vo[i] ^ (16'd1 << $urandom_range(15, 0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, n;
    s_if.s_valid = 1'b0;
    s_if.s_in1   = '0;
    s_if.s_in2   = '0;
    s_if.s_out   = '0;

    // Power-on reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",    32'(busy), 0);
    check("rst_done",    32'(done), 0);
    check("rst_pass",    32'(pass), 0);
    check("rst_vec_cnt", 32'(vec_cnt), 0);
    check("rst_ready",   32'(s_if.s_ready), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Asynchronous reset in the middle of a run
    op_sel = 3'd2; num_vec = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s_if.s_valid = 1'b1; s_if.s_in1 = 16'h1234; s_if.s_in2 = 16'h00FF; s_if.s_out = 16'h0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_err", 32'(err_cnt), 1);
    rst_n = 1'b0;
    #1;
    check("arst_busy",    32'(busy), 0);
    check("arst_ready",   32'(s_if.s_ready), 0);
    check("arst_vec_cnt", 32'(vec_cnt), 0);
    check("arst_err_cnt", 32'(err_cnt), 0);
    check("arst_ff_idx",  32'(first_fail_idx), 0);
    check("arst_ff_got",  32'(first_fail_got), 0);
    check("arst_ff_exp",  32'(first_fail_exp), 0);
    s_if.s_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_busy",  32'(busy), 0);
    check("post_rst_done",  32'(done), 0);
    check("post_rst_ready", 32'(s_if.s_ready), 0);
    check("post_rst_cnt",   32'(vec_cnt), 0);

    // AND, back-to-back directed vectors
    va[0] = 16'h0000; vb[0] = 16'h0000; vo[0] = 16'h0000;
    va[1] = 16'h0000; vb[1] = 16'hFFFF; vo[1] = 16'h0000;
    va[2] = 16'hFFFF; vb[2] = 16'h0000; vo[2] = 16'h0000;
    va[3] = 16'hFFFF; vb[3] = 16'hFFFF; vo[3] = 16'hFFFF;
    va[4] = 16'hF0F0; vb[4] = 16'h0FF0; vo[4] = 16'h00F0;
    va[5] = 16'hAAAA; vb[5] = 16'hBBBB; vo[5] = 16'hAAAA;
    run_vectors(0, 6, 0, 0, -1);

    // Same run with two corrupted responses
    vo[4] = 16'h00F1;
    vo[5] = 16'h0000;
    run_vectors(0, 6, 0, 0, -1);

    // XOR with 1-3 idle cycles between vectors
    fill_random(2, 3, 0);
    run_vectors(2, 3, 1, 3, -1);

    // Empty run, then start ignored while busy, then reserved op
    run_vectors(1, 0, 0, 0, -1);
    fill_random(5, 4, 0);
    run_vectors(5, 4, 0, 1, 1);
    fill_random(7, 3, 0);
    run_vectors(7, 3, 0, 1, -1);
    run_vectors(7, 0, 0, 0, -1);

    // Random runs across all ops
    for (int r = 0; r < 12; r++) begin
      op = int'($urandom_range(7, 0));
      n  = int'($urandom_range(12, 1));
      fill_random(op, n, 25);
      run_vectors(op, n, 0, 2, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
